thrust_ctrl: RTL and testbench
==============================

THRUST_CTRL -- requirements
Module: thrust_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 98425, meaning clk_25 cycles per ramp tick (254 steps take about 1 s).
REQ-002 SHALL have parameter MAX_THRUST, default 254, meaning the upper saturation value of thrust.
REQ-003 SHALL have parameter SLEW_STEP, default 4, meaning the thrust change per tick while slewing to the analog target.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, named as the codebase names them: ports clk_25 and RESET_L.
REQ-005 Ports (name, direction, width, meaning):
- clk_25  in  1  system clock, 25 MHz.
- RESET_L  in  1  asynchronous active-low reset.
- mode_dpad  in  1  1 = D-pad ramp mode, 0 = analog mode.
- up  in  1  D-pad thrust increase, active high.
- down  in  1  D-pad thrust decrease, active high.
- analog_y  in  8  signed stick Y; -128 = full up.
- clr  in  1  synchronous request to force thrust to 0.
- thrust  out  8  unsigned thrust value fed to the game core THRUST input.
- at_max  out  1  thrust == MAX_THRUST.
- at_min  out  1  thrust == 0.
- slewing  out  1  state is SLEW.

Function
REQ-006 Prescaler SHALL count 0..TICK_DIV-1, free-running from reset.
REQ-007 Prescaler SHALL pulse tick for one cycle at count TICK_DIV-1, then wrap to 0.
REQ-008 Mode changes and clr SHALL NOT reset the prescaler.
REQ-009 analog_y SHALL be registered once (ay_q) before use.
REQ-010 Target SHALL be computed in 9-bit signed arithmetic as 127 - ay_q.
REQ-011 The target SHALL then be clamped to MAX_THRUST, giving an 8-bit value: -128 -> 254, 0 -> 127, 127 -> 0.
REQ-012 The FSM SHALL have states DPAD, SLEW and ANALOG.
REQ-013 DPAD -> SLEW when mode_dpad=0.
REQ-014 SLEW -> ANALOG on the cycle after thrust equals target.
REQ-015 ANALOG or SLEW -> DPAD on the cycle after mode_dpad=1.
REQ-016 ANALOG -> SLEW never occurs.
REQ-017 DPAD, on a tick: up&!down with thrust<MAX_THRUST -> thrust+1; down&!up with thrust>0 -> thrust-1.
REQ-018 DPAD, on a tick: up&down, or neither -> hold.
REQ-019 DPAD, with no tick: thrust SHALL hold.
REQ-020 Entering DPAD SHALL keep the current thrust (bumpless transfer); the accumulator SHALL NOT be reloaded.
REQ-021 SLEW, on a tick: thrust SHALL move toward target by min(SLEW_STEP, |target-thrust|), never overshooting.
REQ-022 SLEW: target changes SHALL be tracked continuously.
REQ-023 ANALOG: thrust SHALL equal target every cycle, with a total latency of 2 clk_25 cycles from analog_y to thrust.
REQ-024 clr SHALL take priority over all updates: thrust=0 on the next cycle.
REQ-025 clr SHALL leave the state unchanged, except that ANALOG follows target again on the following cycle.
REQ-026 Simultaneous mode_dpad change and tick: the transition SHALL happen and the tick SHALL be processed by the new state's rule on the next tick only.
REQ-027 thrust SHALL never exceed MAX_THRUST and SHALL never wrap below 0 in any state.
REQ-028 at_max, at_min and slewing SHALL be registered and consistent with thrust/state in the same cycle.

Reset
REQ-029 Asserting RESET_L low SHALL immediately set: thrust=0, at_min=1, at_max=0, slewing=0, state=DPAD, prescaler=0, ay_q=0.
REQ-030 After release, mode_dpad=0 SHALL enter SLEW, so analog power-up ramps from 0 rather than jumping.
REQ-031 Reset mid-ramp or mid-slew SHALL abandon the operation with no residual state.

Structure
REQ-032 The shared package llander_pkg SHALL hold the state enum (DPAD, SLEW, ANALOG) and the default constants TICK_DIV_DEF, MAX_THRUST_DEF and SLEW_STEP_DEF.
REQ-033 The prescaler SHALL be one sub-module, tick_gen (parameter DIV, output tick).
REQ-034 All other logic SHALL be in thrust_ctrl.

Verification (bench uses TICK_DIV=4)
REQ-035 Reset, then mode_dpad=1, up=1 for 260 ticks -> thrust reaches 254 at tick 254, at_max=1, and holds 254 through tick 260.
REQ-036 DPAD with thrust=100, up=down=1 for 10 ticks -> thrust stays 100; then down=1 alone for 3 ticks -> 97.
REQ-037 DPAD with thrust=10, switch to mode_dpad=0 with analog_y=0 -> slewing=1; thrust rises by 4 per tick and reaches 127 on tick 30 (last step +1); ANALOG next cycle, slewing=0.
REQ-038 ANALOG, analog_y steps 0 -> -128 -> 127 -> thrust shows 127, then 254 two cycles later (clamped), then 0 two cycles later.
REQ-039 SLEW mid-ramp with thrust=60, clr pulsed -> thrust=0 next cycle, slewing stays 1, and slewing toward the target resumes.
REQ-040 RESET_L asserted during a DPAD ramp at thrust=80 -> thrust=0 and at_min=1 immediately; after release with mode_dpad=0, state is SLEW and thrust starts from 0.

Source files
------------

// File: rtl/llander_pkg.sv
// Shared definitions for the lander control blocks: thrust FSM states,
// default timing/saturation constants and the analog stick-to-target mapping.
package llander_pkg;

  typedef enum logic [1:0] {
    DPAD   = 2'd0,
    SLEW   = 2'd1,
    ANALOG = 2'd2
  } thrust_state_t;

  localparam int TICK_DIV_DEF   = 98425;
  localparam int MAX_THRUST_DEF = 254;
  localparam int SLEW_STEP_DEF  = 4;

  // Stick Y is signed with -128 = full up; full up maps to maximum thrust.
  function automatic logic [7:0] analog_target(input logic [7:0] ay,
                                               input logic [7:0] max_t);
    logic signed [8:0] t9;
    logic [7:0]        result;
    t9 = 9'sd127 - $signed({ay[7], ay});
    if (t9[8]) begin
      result = 8'd0;
    end else if (t9[7:0] > max_t) begin
      result = max_t;
    end else begin
      result = t9[7:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/thrust_ctrl_if.sv
// Control/status bundle between a thrust source (pad/stick logic or bench)
// and thrust_ctrl.
interface thrust_ctrl_if (
  input logic clk_25
);
  // Every signal is level-sampled on each rising clk_25 edge; there is no
  // valid/ready handshake, a value is consumed simply by being present.
  logic       mode_dpad;
  logic       up;
  logic       down;
  logic [7:0] analog_y;
  logic       clr;
  logic [7:0] thrust;
  logic       at_max;
  logic       at_min;
  logic       slewing;

  modport master (
    input  clk_25,
    output mode_dpad, up, down, analog_y, clr,
    input  thrust, at_max, at_min, slewing
  );

  modport slave (
    input  clk_25,
    input  mode_dpad, up, down, analog_y, clr,
    output thrust, at_max, at_min, slewing
  );

endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, on the last count.
module tick_gen
  import llander_pkg::*;
#(
  parameter int DIV = TICK_DIV_DEF
) (
  input  logic clk_25,
  input  logic RESET_L,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/thrust_ctrl.sv
// Lander thrust controller: D-pad ramp mode, rate-limited slew onto the
// analog stick target, then direct analog tracking.
module thrust_ctrl
  import llander_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int MAX_THRUST = MAX_THRUST_DEF,
  parameter int SLEW_STEP  = SLEW_STEP_DEF
) (
  input  logic       clk_25,
  input  logic       RESET_L,
  input  logic       mode_dpad,
  input  logic       up,
  input  logic       down,
  input  logic [7:0] analog_y,
  input  logic       clr,
  output logic [7:0] thrust,
  output logic       at_max,
  output logic       at_min,
  output logic       slewing
);

  localparam logic [7:0] MAX8  = 8'(MAX_THRUST);
  localparam logic [7:0] STEP8 = 8'(SLEW_STEP);

  logic          tick;
  logic [7:0]    ay_q;
  logic [7:0]    target;
  logic [7:0]    slew_gap;
  logic [7:0]    slew_amt;
  logic [7:0]    next_thrust;
  thrust_state_t state;
  thrust_state_t next_state;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_25  (clk_25),
    .RESET_L (RESET_L),
    .tick    (tick)
  );

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      ay_q <= '0;
    end else begin
      ay_q <= analog_y;
    end
  end

  assign target = analog_target(ay_q, MAX8);

  // A mode change consumes its cycle: any coincident tick is dropped and the
  // new state's rule applies from the following tick on.
  always_comb begin
    next_state  = state;
    next_thrust = thrust;
    slew_gap    = (target >= thrust) ? (target - thrust) : (thrust - target);
    slew_amt    = (slew_gap < STEP8) ? slew_gap : STEP8;
    if (clr) begin
      next_thrust = '0;
    end else begin
      case (state)
        DPAD: begin
          if (!mode_dpad) begin
            next_state = SLEW;
          end else if (tick) begin
            if (up && !down && (thrust < MAX8)) begin
              next_thrust = thrust + 8'd1;
            end else if (down && !up && (thrust != 8'd0)) begin
              next_thrust = thrust - 8'd1;
            end
          end
        end
        SLEW: begin
          if (mode_dpad) begin
            next_state = DPAD;
          end else begin
            if (thrust == target) begin
              next_state = ANALOG;
            end
            if (tick) begin
              next_thrust = (target > thrust) ? (thrust + slew_amt)
                                              : (thrust - slew_amt);
            end
          end
        end
        ANALOG: begin
          if (mode_dpad) begin
            next_state = DPAD;
          end else begin
            next_thrust = target;
          end
        end
        default: begin
          next_state = DPAD;
        end
      endcase
    end
  end

  // Flags are derived from the next values so they line up with thrust.
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      state   <= DPAD;
      thrust  <= '0;
      at_max  <= 1'b0;
      at_min  <= 1'b1;
      slewing <= 1'b0;
    end else begin
      state   <= next_state;
      thrust  <= next_thrust;
      at_max  <= (next_thrust == MAX8);
      at_min  <= (next_thrust == 8'd0);
      slewing <= (next_state == SLEW);
    end
  end

endmodule

// File: tb/tb_thrust_ctrl.sv
// Self-checking bench for thrust_ctrl: directed scenarios plus random traffic,
// all checked against a cycle-level reference model of the control rules.
module tb_thrust_ctrl;

  localparam int DIV  = 4;
  localparam int MAX  = 254;
  localparam int STEP = 4;

  // clock / reset
  logic clk_25 = 1'b0;
  logic RESET_L;
  always #5 clk_25 = ~clk_25;

  thrust_ctrl_if bus (.clk_25(clk_25));

  thrust_ctrl #(
    .TICK_DIV   (DIV),
    .MAX_THRUST (MAX),
    .SLEW_STEP  (STEP)
  ) dut (
    .clk_25    (clk_25),
    .RESET_L   (RESET_L),
    .mode_dpad (bus.mode_dpad),
    .up        (bus.up),
    .down      (bus.down),
    .analog_y  (bus.analog_y),
    .clr       (bus.clr),
    .thrust    (bus.thrust),
    .at_max    (bus.at_max),
    .at_min    (bus.at_min),
    .slewing   (bus.slewing)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard: {thrust[7:0], at_max, at_min, slewing}
  logic [10:0] exp_q[$];

  // reference model
  typedef enum {M_DPAD, M_SLEW, M_ANALOG} model_st_t;
  model_st_t m_st;
  int        m_thr;
  int        m_cnt;
  int        m_ay;
  int        m_ticks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st  = M_DPAD;
    m_thr = 0;
    m_cnt = 0;
    m_ay  = 0;
  endtask

  task automatic model_step();
    int  tgt;
    int  d;
    bit  tick;
    tgt  = 127 - m_ay;
    if (tgt > MAX) tgt = MAX;
    if (tgt < 0) tgt = 0;
    tick = (m_cnt == DIV - 1);
    if (bus.clr) begin
      m_thr = 0;
    end else begin
      case (m_st)
        M_DPAD: begin
          if (!bus.mode_dpad) m_st = M_SLEW;
          else if (tick) begin
            if (bus.up && !bus.down) m_thr = (m_thr < MAX) ? m_thr + 1 : MAX;
            else if (bus.down && !bus.up) m_thr = (m_thr > 0) ? m_thr - 1 : 0;
          end
        end
        M_SLEW: begin
          if (bus.mode_dpad) m_st = M_DPAD;
          else begin
            if (tick) begin
              d = tgt - m_thr;
              if (d > STEP) d = STEP;
              if (d < -STEP) d = -STEP;
              m_thr = m_thr + d;
            end
            if (m_thr - d == tgt || (!tick && m_thr == tgt)) m_st = M_ANALOG;
          end
        end
        default: begin
          if (bus.mode_dpad) m_st = M_DPAD;
          else m_thr = tgt;
        end
      endcase
    end
    if (tick) m_ticks++;
    m_ay  = int'($signed(bus.analog_y));
    m_cnt = tick ? 0 : m_cnt + 1;
  endtask

  function automatic logic [10:0] exp_word();
    logic [7:0] t;
    t = 8'(m_thr);
    return {t, (m_thr == MAX), (m_thr == 0), (m_st == M_SLEW)};
  endfunction

  // driver tasks
  task automatic set_in(input bit mode, input bit u, input bit dn,
                        input logic [7:0] ay, input bit c);
    bus.mode_dpad = mode;
    bus.up        = u;
    bus.down      = dn;
    bus.analog_y  = ay;
    bus.clr       = c;
  endtask

  task automatic cycle();
    logic [10:0] e;
    @(posedge clk_25);
    if (!RESET_L) model_reset();
    else model_step();
    exp_q.push_back(exp_word());
    @(negedge clk_25);
    e = exp_q.pop_front();
    check("thrust", 32'(bus.thrust), 32'(e[10:3]));
    check("flags", 32'({bus.at_max, bus.at_min, bus.slewing}), 32'(e[2:0]));
  endtask

  task automatic wait_ticks(input int n);
    int goal;
    int budget;
    goal   = m_ticks + n;
    budget = n * DIV + 8;
    while (m_ticks < goal && budget > 0) begin
      cycle();
      budget--;
    end
    if (m_ticks < goal) check("tick_budget", 32'(m_ticks), 32'(goal));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         r_mode;
    bit         r_up;
    bit         r_dn;
    logic [7:0] r_ay;
    RESET_L = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    model_reset();
    repeat (2) cycle();
    check("reset_thrust", 32'(bus.thrust), 0);
    check("reset_flags", 32'({bus.at_max, bus.at_min, bus.slewing}), 32'(3'b010));
    RESET_L = 1'b1;

    // D-pad ramp to saturation
    set_in(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    wait_ticks(254);
    check("ramp_254", 32'(bus.thrust), 254);
    check("ramp_at_max", 32'(bus.at_max), 1);
    wait_ticks(6);
    check("ramp_hold_260", 32'(bus.thrust), 254);

    // D-pad down, both pressed, down again
    set_in(1'b1, 1'b0, 1'b1, 8'd0, 1'b0);
    wait_ticks(154);
    check("down_to_100", 32'(bus.thrust), 100);
    set_in(1'b1, 1'b1, 1'b1, 8'd0, 1'b0);
    wait_ticks(10);
    check("both_hold_100", 32'(bus.thrust), 100);
    set_in(1'b1, 1'b0, 1'b1, 8'd0, 1'b0);
    wait_ticks(3);
    check("down3_97", 32'(bus.thrust), 97);
    wait_ticks(87);
    check("down_to_10", 32'(bus.thrust), 10);

    // slew from 10 to the centre-stick target 127
    set_in(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    cycle();
    check("slew_entry", 32'(bus.slewing), 1);
    check("slew_bumpless", 32'(bus.thrust), 10);
    wait_ticks(29);
    check("slew_29", 32'(bus.thrust), 126);
    wait_ticks(1);
    check("slew_30", 32'(bus.thrust), 127);
    cycle();
    check("analog_entry", 32'(bus.slewing), 0);

    // analog tracking with two-cycle latency and clamping
    set_in(1'b0, 1'b0, 1'b0, 8'h80, 1'b0);
    cycle();
    check("analog_lat1", 32'(bus.thrust), 127);
    cycle();
    check("analog_full_up", 32'(bus.thrust), 254);
    check("analog_at_max", 32'(bus.at_max), 1);
    set_in(1'b0, 1'b0, 1'b0, 8'd127, 1'b0);
    cycle();
    cycle();
    check("analog_full_down", 32'(bus.thrust), 0);
    check("analog_at_min", 32'(bus.at_min), 1);

    // clr during a slew at 60
    set_in(1'b0, 1'b0, 1'b0, 8'd67, 1'b0);
    cycle();
    cycle();
    check("analog_60", 32'(bus.thrust), 60);
    set_in(1'b1, 1'b0, 1'b0, 8'd67, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    cycle();
    check("slew_60", 32'(bus.thrust), 60);
    set_in(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    cycle();
    check("clr_zero", 32'(bus.thrust), 0);
    check("clr_slewing", 32'(bus.slewing), 1);
    set_in(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    wait_ticks(1);
    check("clr_resume", 32'(bus.thrust), 4);

    // reset in the middle of a D-pad ramp
    set_in(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    cycle();
    wait_ticks(76);
    check("ramp_80", 32'(bus.thrust), 80);
    RESET_L = 1'b0;
    #1;
    check("async_rst_thrust", 32'(bus.thrust), 0);
    check("async_rst_flags", 32'({bus.at_max, bus.at_min, bus.slewing}), 32'(3'b010));
    model_reset();
    set_in(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    cycle();
    RESET_L = 1'b1;
    cycle();
    check("post_rst_slew", 32'(bus.slewing), 1);
    check("post_rst_thrust", 32'(bus.thrust), 0);
    wait_ticks(1);
    check("post_rst_ramp", 32'(bus.thrust), 4);

    // random traffic against the model
    r_mode = 1'b0;
    r_up   = 1'b0;
    r_dn   = 1'b0;
    r_ay   = 8'd0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) r_mode = ~r_mode;
      if ($urandom_range(0, 7) == 0) begin
        r_up = 1'($urandom_range(0, 1));
        r_dn = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 19) == 0) r_ay = 8'($urandom_range(0, 255));
      set_in(r_mode, r_up, r_dn, r_ay, ($urandom_range(0, 99) == 0));
      RESET_L = ($urandom_range(0, 399) != 0);
      cycle();
    end
    RESET_L = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
